// File: rtl/l2_config_and_types.sv
// rtl/l2_config_and_types.sv - shared L2 widths and arbiter FSM state type
package l2_config_and_types;

   localparam int L2_ID_W   = 3;
   localparam int L2_ADDR_W = 30;
   localparam int L2_DATA_W = 32;
   localparam int L2_BE_W   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      WDATA = 2'd2
   } arb_state_e;

endpackage

// File: rtl/l2_memory_interface.sv
// rtl/l2_memory_interface.sv - L2 request / write-data / read-return bus
interface l2_memory_interface #(
   parameter int BURST_W = 5
);
   import l2_config_and_types::*;

   logic                 request_valid;
   logic                 rnw;
   logic                 is_amo;
   logic [L2_ADDR_W-1:0] addr;
   logic [BURST_W-1:0]   amo_type_or_burst_size;
   logic [L2_ID_W-1:0]   id;
   logic                 wr_data_valid;
   logic [L2_DATA_W-1:0] wr_data;
   logic [L2_BE_W-1:0]   wr_data_be;
   logic                 request_pop;
   logic                 wr_data_read;
   logic [L2_DATA_W-1:0] rd_data;
   logic [L2_ID_W-1:0]   rd_id;
   logic                 rd_data_valid;

   modport master (
      output request_valid, rnw, is_amo, addr, amo_type_or_burst_size, id,
             wr_data_valid, wr_data, wr_data_be,
      input  request_pop, wr_data_read, rd_data, rd_id, rd_data_valid
   );

   modport slave (
      input  request_valid, rnw, is_amo, addr, amo_type_or_burst_size, id,
             wr_data_valid, wr_data, wr_data_be,
      output request_pop, wr_data_read, rd_data, rd_id, rd_data_valid
   );

endinterface

// File: rtl/l2_rr_select.sv
// rtl/l2_rr_select.sv - combinational round-robin pick starting at ptr
module l2_rr_select #(
   parameter int NUM_PORTS = 4,
   parameter int IDX_W     = 2
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [NUM_PORTS-1:0] onehot,
   output logic [IDX_W-1:0]     idx
);

   logic             hit;
   logic [IDX_W-1:0] cand;

   // walk ports from ptr upward with wrap; the first pending one wins
   always_comb begin
      onehot = '0;
      idx    = '0;
      hit    = 1'b0;
      cand   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = IDX_W'((int'(ptr) + i) % NUM_PORTS);
         if (!hit && req[cand]) begin
            hit          = 1'b1;
            onehot[cand] = 1'b1;
            idx          = cand;
         end
      end
   end

endmodule

// File: rtl/l2_request_arbiter.sv
// rtl/l2_request_arbiter.sv - round-robin arbiter of N requesters onto one L2 port
module l2_request_arbiter
   import l2_config_and_types::*;
#(
   parameter int NUM_PORTS   = 4,
   parameter int MAX_BURST_W = 5
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_PORTS-1:0]           req_valid,
   input  logic [NUM_PORTS-1:0]           req_rnw,
   input  logic [NUM_PORTS-1:0]           req_is_amo,
   input  logic [NUM_PORTS*L2_ADDR_W-1:0] req_addr,
   input  logic [NUM_PORTS*MAX_BURST_W-1:0] req_burst,
   output logic [NUM_PORTS-1:0]           req_pop,
   input  logic [NUM_PORTS-1:0]           wr_valid,
   input  logic [NUM_PORTS*L2_DATA_W-1:0] wr_data,
   input  logic [NUM_PORTS*L2_BE_W-1:0]   wr_be,
   output logic [NUM_PORTS-1:0]           wr_read,
   output logic [NUM_PORTS-1:0]           rd_valid,
   output logic [L2_DATA_W-1:0]           rd_data,
   l2_memory_interface.master             l2
);

   localparam int IDX_W = $clog2(NUM_PORTS);
   localparam int CNT_W = MAX_BURST_W + 1;

   if (L2_ID_W < IDX_W) begin : g_id_w_check
      $error("L2_ID_W is too narrow to carry every port index");
   end

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   // in ADDR: beats already taken; in WDATA: beats still owed
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [NUM_PORTS-1:0]   rr_onehot;
   logic [IDX_W-1:0]       rr_idx;
   logic                   sel_rnw, sel_amo, pure_read;
   logic [MAX_BURST_W-1:0] sel_burst;
   logic [CNT_W-1:0]       beats_needed, consumed;
   logic [IDX_W-1:0]       ptr_after;

   l2_rr_select #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_rr (
      .req    (req_valid),
      .ptr    (ptr_q),
      .onehot (rr_onehot),
      .idx    (rr_idx)
   );

   assign sel_rnw      = req_rnw[grant_q];
   assign sel_amo      = req_is_amo[grant_q];
   assign sel_burst    = req_burst[int'(grant_q)*MAX_BURST_W +: MAX_BURST_W];
   assign pure_read    = sel_rnw && !sel_amo;
   assign beats_needed = !sel_rnw ? CNT_W'(sel_burst) + CNT_W'(1) : CNT_W'(1);
   assign ptr_after    = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

   // request fields always follow the registered grant, never req_valid directly
   assign l2.rnw                    = sel_rnw;
   assign l2.is_amo                 = sel_amo;
   assign l2.addr                   = req_addr[int'(grant_q)*L2_ADDR_W +: L2_ADDR_W];
   assign l2.amo_type_or_burst_size = sel_burst;
   assign l2.id                     = L2_ID_W'(grant_q);
   assign l2.wr_data                = wr_data[int'(grant_q)*L2_DATA_W +: L2_DATA_W];
   assign l2.wr_data_be             = wr_be[int'(grant_q)*L2_BE_W +: L2_BE_W];

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // next state: grant in IDLE, hand-off on pop, count write beats to the end
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      consumed = cnt_q + CNT_W'(l2.wr_data_read);
      case (state_q)
         IDLE: begin
            if (|rr_onehot) begin
               grant_d = rr_idx;
               cnt_d   = '0;
               state_d = ADDR;
            end
         end
         ADDR: begin
            cnt_d = consumed;
            if (l2.request_pop) begin
               if (pure_read || consumed >= beats_needed) begin
                  state_d = IDLE;
                  ptr_d   = ptr_after;
                  cnt_d   = '0;
               end else begin
                  state_d = WDATA;
                  cnt_d   = beats_needed - consumed;
               end
            end
         end
         WDATA: begin
            if (l2.wr_data_read) begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_d = IDLE;
                  ptr_d   = ptr_after;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // outputs: request valid only in ADDR, write data path open in ADDR and WDATA
   always_comb begin
      l2.request_valid = 1'b0;
      l2.wr_data_valid = 1'b0;
      req_pop          = '0;
      wr_read          = '0;
      if (state_q == ADDR) begin
         l2.request_valid = 1'b1;
         req_pop[grant_q] = l2.request_pop;
      end
      if (state_q != IDLE) begin
         l2.wr_data_valid = wr_valid[grant_q];
         wr_read[grant_q] = l2.wr_data_read;
      end
   end

   // read return is routed by id regardless of arbitration state
   always_comb begin
      rd_data = l2.rd_data;
      for (int i = 0; i < NUM_PORTS; i++) begin
         rd_valid[i] = l2.rd_data_valid && (l2.rd_id == L2_ID_W'(i));
      end
   end

endmodule

// File: doc/l2_request_arbiter.md
L2_REQUEST_ARBITER -- requirements
Module: l2_request_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of requesters (2..8); port i uses L2 id i.
REQ-002 SHALL have parameter MAX_BURST_W, default 5, width of the burst-length field (beats = value+1).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  NUM_PORTS  per-port request pending.
REQ-006 req_rnw / req_is_amo  input  NUM_PORTS each  per-port read-not-write / atomic flag.
REQ-007 req_addr  input  NUM_PORTS*30  per-port word address.
REQ-008 req_burst  input  NUM_PORTS*5  per-port burst length or AMO op code.
REQ-009 req_pop  output  NUM_PORTS  one-hot; the port's request was accepted downstream.
REQ-010 wr_valid / wr_data / wr_be  input  NUM_PORTS / NUM_PORTS*32 / NUM_PORTS*4  per-port write-data FIFO head.
REQ-011 wr_read  output  NUM_PORTS  one-hot; the port's write-data head was consumed.
REQ-012 rd_valid  output  NUM_PORTS  per-port read-data strobe; rd_data output 32, shared read data.
REQ-013 l2 (l2_memory_interface.master)  SHALL drive request_valid, rnw, is_amo, addr, amo_type_or_burst_size, id, wr_data_valid, wr_data, wr_data_be; SHALL receive request_pop, wr_data_read, rd_data, rd_id, rd_data_valid.

Function
REQ-014 FSM states SHALL be IDLE, ADDR, WDATA.
REQ-015 IDLE: when any req_valid set, SHALL select winner by round-robin from pointer ptr (first set bit at or above ptr, wrapping), register grant, go to ADDR; no request -> stay IDLE.
REQ-016 ADDR: l2.request_valid SHALL be 1 and all l2 request fields SHALL be the granted port's (registered-grant mux, no combinational path from req_valid to request_valid).
REQ-017 ADDR on l2.request_pop: req_pop[grant]=1 that cycle; rnw=1 and is_amo=0 -> IDLE; otherwise -> WDATA with beat counter loaded to (rnw=0 ? burst+1 : 1).
REQ-018 Write data SHALL be muxed from grant in ADDR and WDATA; l2.wr_data_valid = wr_valid[grant]; wr_read[grant] = l2.wr_data_read; other wr_read bits 0.
REQ-019 WDATA: counter (6 bits, range 1..32) SHALL decrement on each l2.wr_data_read; on the read that takes it from 1 to 0 -> IDLE.
REQ-020 Beats consumed in ADDR (same-cycle read before pop) SHALL count toward the burst.
REQ-021 On leaving ADDR (read) or WDATA (write/AMO), ptr SHALL become (grant+1) mod NUM_PORTS.
REQ-022 Minimum request-to-request spacing SHALL be one IDLE cycle; latency req_valid -> l2.request_valid SHALL be exactly 1 cycle from IDLE.
REQ-023 Grant SHALL NOT change while in ADDR or WDATA even if the granted port drops req_valid (protocol violation; hold).
REQ-024 Read return SHALL be independent of FSM: rd_valid[i] = l2.rd_data_valid && l2.rd_id == i; rd_data = l2.rd_data.
REQ-025 l2.id SHALL equal grant zero-extended to L2_ID_W.
REQ-026 IDLE outputs: l2.request_valid=0, l2.wr_data_valid=0, req_pop=0, wr_read=0.

Reset
REQ-027 rst SHALL force state IDLE, ptr=0, grant=0, counter=0, all outputs in REQ-026 to 0, from any state including mid-burst; in-flight reads still route per REQ-024.

Structure
REQ-028 The FSM state enum SHALL live in l2_config_and_types; L2_ID_W SHALL be taken from it and SHALL be >= clog2(NUM_PORTS).
REQ-029 Round-robin selection SHALL be one sub-module l2_rr_select (inputs request vector, ptr; outputs one-hot and index), purely combinational.

Verification
REQ-030 Ports 0,2 read (burst 7) together, ptr=0 -> port 0 granted cycle 1, pop, IDLE, port 2 granted; ptr ends 3.
REQ-031 Port 1 write burst 3 (4 beats), wr_data_read held 1 -> exactly 4 wr_read[1] pulses, then IDLE, ptr=2.
REQ-032 All 4 ports request continuously reads -> grant order 0,1,2,3,0; no port starved.
REQ-033 Port 3 AMO with pop and wr_data_read same cycle -> req_pop[3] and wr_read[3] once each, direct return to IDLE.
REQ-034 rst asserted during WDATA after 2 of 8 beats -> next cycle IDLE, ptr=0, no further wr_read.
REQ-035 rd_data_valid with rd_id=2 during port 0 write -> rd_valid=4'b0100, write unaffected.
